// File: rtl/amci_arbiter.sv
// amci_arbiter: two-client round-robin front end for an AXI4-Lite master's
// write/read control interfaces. Each client gets a one-deep pending slot.
// Requests are issued one at a time: IDLE -> ISSUE -> WAIT -> IDLE.
module amci_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  // client 0
  input  logic          C0_REQ,
  input  logic          C0_RNW,
  input  logic [AW-1:0] C0_ADDR,
  input  logic [DW-1:0] C0_WDATA,
  output logic          C0_BUSY,
  output logic          C0_DONE,
  output logic [DW-1:0] C0_RDATA,
  output logic [1:0]    C0_RESP,
  output logic          C0_OVERRUN,
  // client 1
  input  logic          C1_REQ,
  input  logic          C1_RNW,
  input  logic [AW-1:0] C1_ADDR,
  input  logic [DW-1:0] C1_WDATA,
  output logic          C1_BUSY,
  output logic          C1_DONE,
  output logic [DW-1:0] C1_RDATA,
  output logic [1:0]    C1_RESP,
  output logic          C1_OVERRUN,
  // master write control
  output logic [AW-1:0] AMCI_WADDR,
  output logic [DW-1:0] AMCI_WDATA,
  output logic          AMCI_WRITE,
  input  logic [1:0]    AMCI_WRESP,
  input  logic          AMCI_WIDLE,
  // master read control
  output logic [AW-1:0] AMCI_RADDR,
  output logic          AMCI_READ,
  input  logic [DW-1:0] AMCI_RDATA,
  input  logic [1:0]    AMCI_RRESP,
  input  logic          AMCI_RIDLE
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
  state_t state_reg, state_next;

  // Client inputs gathered into arrays so both slots share one description
  logic [1:0]    req, req_rnw;
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];

  logic [1:0]    pend_valid, pend_rnw, done, overrun;
  logic [AW-1:0] pend_addr  [2];
  logic [DW-1:0] pend_wdata [2];
  logic [DW-1:0] rdata      [2];
  logic [1:0]    resp       [2];

  logic          grant_sel, grant_reg, last_reg;
  logic          can_grant, wait_idle, finish;
  logic          write_next, read_next;
  logic          write_reg, read_reg;
  logic [AW-1:0] waddr_reg, raddr_reg;
  logic [DW-1:0] wdata_reg;

  assign req          = {C1_REQ, C0_REQ};
  assign req_rnw      = {C1_RNW, C0_RNW};
  assign req_addr[0]  = C0_ADDR;
  assign req_addr[1]  = C1_ADDR;
  assign req_wdata[0] = C0_WDATA;
  assign req_wdata[1] = C1_WDATA;

  // On a tie the client not granted last time wins; otherwise the sole requester
  assign grant_sel = (pend_valid == 2'b11) ? ~last_reg : ~pend_valid[0];
  // Only start a transfer when the master is idle in both directions
  assign can_grant = (|pend_valid) && AMCI_WIDLE && AMCI_RIDLE;
  // Completion is judged on the idle flag of the direction actually issued
  assign wait_idle = pend_rnw[grant_reg] ? AMCI_RIDLE : AMCI_WIDLE;
  assign finish    = (state_reg == WAIT) && wait_idle;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (can_grant) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_idle) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobe decode: a strobe is only raised on the grant out of IDLE
  always_comb begin
    write_next = 1'b0;
    read_next  = 1'b0;
    if (state_reg == IDLE && can_grant) begin
      write_next = ~pend_rnw[grant_sel];
      read_next  =  pend_rnw[grant_sel];
    end
  end

  // Master-side registers, grant bookkeeping and round-robin history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_reg <= 1'b0;
      read_reg  <= 1'b0;
      waddr_reg <= '0;
      raddr_reg <= '0;
      wdata_reg <= '0;
      grant_reg <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      write_reg <= write_next;
      read_reg  <= read_next;
      if (state_reg == IDLE && can_grant) begin
        grant_reg <= grant_sel;
        wdata_reg <= pend_wdata[grant_sel];
        if (pend_rnw[grant_sel]) raddr_reg <= pend_addr[grant_sel];
        else                     waddr_reg <= pend_addr[grant_sel];
      end
      if (finish) last_reg <= grant_reg;
    end
  end

  // Per-client pending slot, completion capture and overrun flag
  for (genvar gi = 0; gi < 2; gi++) begin : g_client
    logic          valid_reg, rnw_reg, done_reg, overrun_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg_c, rdata_reg;
    logic [1:0]    resp_reg;
    logic          mine;

    assign mine = finish && (grant_reg == 1'(gi));

    // Capture new requests, clear the slot when its transfer completes
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_reg   <= 1'b0;
        rnw_reg     <= 1'b0;
        addr_reg    <= '0;
        wdata_reg_c <= '0;
        done_reg    <= 1'b0;
        overrun_reg <= 1'b0;
        rdata_reg   <= '0;
        resp_reg    <= '0;
      end else begin
        overrun_reg <= req[gi] && valid_reg;
        done_reg    <= mine;
        if (mine) begin
          valid_reg <= 1'b0;
          resp_reg  <= rnw_reg ? AMCI_RRESP : AMCI_WRESP;
          if (rnw_reg) rdata_reg <= AMCI_RDATA;
        end else if (req[gi] && !valid_reg) begin
          valid_reg   <= 1'b1;
          rnw_reg     <= req_rnw[gi];
          addr_reg    <= req_addr[gi];
          wdata_reg_c <= req_wdata[gi];
        end
      end
    end

    assign pend_valid[gi] = valid_reg;
    assign pend_rnw[gi]   = rnw_reg;
    assign pend_addr[gi]  = addr_reg;
    assign pend_wdata[gi] = wdata_reg_c;
    assign done[gi]       = done_reg;
    assign overrun[gi]    = overrun_reg;
    assign rdata[gi]      = rdata_reg;
    assign resp[gi]       = resp_reg;
  end

  assign C0_BUSY    = pend_valid[0];
  assign C0_DONE    = done[0];
  assign C0_RDATA   = rdata[0];
  assign C0_RESP    = resp[0];
  assign C0_OVERRUN = overrun[0];
  assign C1_BUSY    = pend_valid[1];
  assign C1_DONE    = done[1];
  assign C1_RDATA   = rdata[1];
  assign C1_RESP    = resp[1];
  assign C1_OVERRUN = overrun[1];

  assign AMCI_WADDR = waddr_reg;
  assign AMCI_WDATA = wdata_reg;
  assign AMCI_WRITE = write_reg;
  assign AMCI_RADDR = raddr_reg;
  assign AMCI_READ  = read_reg;

endmodule
